// File: rtl/rf_pkg.sv
// Shared register-file write types.
// Used by the WB stage, the long-latency unit and the write arbiter.
package rf_pkg;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } rf_wr_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-side bundle between producers and the register-file arbiter.
// master = producers/ID/regfile side, slave = the arbiter.
interface rf_write_arbiter_if
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic            pipe_we;
    logic [AW-1:0]   pipe_wa;
    logic [DW-1:0]   pipe_wd;
    logic            lu_valid;
    logic            lu_ready;
    logic [AW-1:0]   lu_wa;
    logic [DW-1:0]   lu_wd;
    logic            issue_valid;
    logic [AW-1:0]   issue_wa;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [DW-1:0]   rf_wd;
    logic [NREG-1:0] busy;
    logic [CW-1:0]   q_count;
    logic            err;

    modport master (
        output pipe_we, pipe_wa, pipe_wd,
        output lu_valid, lu_wa, lu_wd,
        output issue_valid, issue_wa,
        input  lu_ready, rf_we, rf_wa, rf_wd,
        input  busy, q_count, err
    );

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd,
        input  lu_valid, lu_wa, lu_wd,
        input  issue_valid, issue_wa,
        output lu_ready, rf_we, rf_wa, rf_wd,
        output busy, q_count, err
    );
endinterface

// File: rtl/rf_write_arbiter_sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] LP_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != LP_FULL);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Regfile write-port arbiter: WB has priority, long-latency results queue.
// Also tracks pending long-latency destinations for ID hazard checks.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

    logic            w_pipe_act;
    logic            w_empty;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_err_set;
    rf_wr_t          w_din;
    rf_wr_t          w_head;
    logic [CW-1:0]   w_count;
    logic [NREG-1:0] w_busy_nxt;
    logic [NREG-1:0] r_busy;
    logic            r_err;

    assign w_pipe_act = bus.pipe_we && (bus.pipe_wa != '0);
    assign w_empty    = (w_count == '0);
    assign w_accept   = bus.lu_valid && bus.lu_ready;
    assign w_push     = w_accept && (bus.lu_wa != '0);
    assign w_pop      = !rst && !w_pipe_act && !w_empty;
    assign w_issue    = bus.issue_valid && (bus.issue_wa != '0);
    assign w_din      = '{wa: bus.lu_wa, wd: bus.lu_wd};

    sync_fifo #(
        .WIDTH ($bits(rf_wr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Depends on registered occupancy only, never on the WB stage.
    assign bus.lu_ready = !rst && (w_count != LP_FULL);
    assign bus.q_count  = w_count;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;

    always_comb begin
        bus.rf_we = 1'b0;
        bus.rf_wa = '0;
        bus.rf_wd = '0;
        if (!rst) begin
            if (w_pipe_act) begin
                bus.rf_we = 1'b1;
                bus.rf_wa = bus.pipe_wa;
                bus.rf_wd = bus.pipe_wd;
            end else if (!w_empty) begin
                bus.rf_we = 1'b1;
                bus.rf_wa = w_head.wa;
                bus.rf_wd = w_head.wd;
            end
        end
    end

    // Clear first so a same-cycle issue to the popped register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head.wa] = 1'b0;
        end
        if (w_issue) begin
            w_busy_nxt[bus.issue_wa] = 1'b1;
        end
    end

    assign w_err_set =
        (w_issue && r_busy[bus.issue_wa] &&
         !(w_pop && (w_head.wa == bus.issue_wa))) ||
        (w_push && !r_busy[bus.lu_wa]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= r_err || w_err_set;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed plan steps, then random traffic,
// all compared against a queue-based model of the write port.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rf_wr_t      mq[$];
    logic [31:0] mbusy;
    logic        merr;

    rf_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

    rf_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(bit pw, int pwa, logic [31:0] pwd,
                       bit lv, int lwa, logic [31:0] lwd,
                       bit iv, int iwa);
        bus.pipe_we     = pw;
        bus.pipe_wa     = 5'(pwa);
        bus.pipe_wd     = pwd;
        bus.lu_valid    = lv;
        bus.lu_wa       = 5'(lwa);
        bus.lu_wd       = lwd;
        bus.issue_valid = iv;
        bus.issue_wa    = 5'(iwa);
    endtask

    // One clock: compare outputs to the model, then advance the model.
    task automatic cyc();
        bit          act;
        bit          rdy;
        bit          pop;
        bit          acc;
        bit          ewe;
        bit          ne;
        rf_wr_t      hd;
        rf_wr_t      nw;
        logic [31:0] nb;
        logic [4:0]  iwa;
        bit          iv;
        bit          r;
        #1;
        r   = rst;
        act = bus.pipe_we && bus.pipe_wa != 0;
        rdy = !r && mq.size() < DEPTH;
        pop = !r && !act && mq.size() > 0;
        hd  = (mq.size() > 0) ? mq[0] : '0;
        ewe = !r && (act || mq.size() > 0);
        acc = rdy && bus.lu_valid && bus.lu_wa != 0;
        nw  = '{wa: bus.lu_wa, wd: bus.lu_wd};
        iv  = bus.issue_valid && bus.issue_wa != 0;
        iwa = bus.issue_wa;
        chk("rf_we", 32'(bus.rf_we), 32'(ewe));
        chk("rf_wa", 32'(bus.rf_wa),
            !ewe ? 32'd0 : act ? 32'(bus.pipe_wa) : 32'(hd.wa));
        chk("rf_wd", bus.rf_wd,
            !ewe ? 32'd0 : act ? bus.pipe_wd : hd.wd);
        chk("lu_ready", 32'(bus.lu_ready), 32'(rdy));
        chk("q_count", 32'(bus.q_count), 32'(mq.size()));
        chk("busy", bus.busy, mbusy);
        chk("err", 32'(bus.err), 32'(merr));
        ne = merr;
        if (iv && mbusy[iwa] && !(pop && hd.wa == iwa)) ne = 1'b1;
        if (acc && !mbusy[nw.wa]) ne = 1'b1;
        nb = mbusy;
        if (pop) nb[hd.wa] = 1'b0;
        if (iv) nb[iwa] = 1'b1;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mbusy = '0;
            merr  = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(nw);
            mbusy = nb;
            merr  = ne;
        end
        @(negedge clk);
    endtask

    task automatic step(bit pw, int pwa, logic [31:0] pwd,
                        bit lv, int lwa, logic [31:0] lwd,
                        bit iv, int iwa);
        drv(pw, pwa, pwd, lv, lwa, lwd, iv, iwa);
        cyc();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int          lwa;
        int          busy_list[$];
        errors = 0;
        checks = 0;
        mq.delete();
        mbusy = '0;
        merr  = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and first cycle after release
        #1;
        chk("reset_ready", 32'(bus.lu_ready), 32'd1);
        chk("reset_qcount", 32'(bus.q_count), 32'd0);
        chk("reset_busy", bus.busy, 32'd0);
        idle();

        // Priority of WB over the queue
        step(0, 0, 0, 0, 0, 0, 1, 7);
        step(0, 0, 0, 1, 7, 32'h55, 0, 0);
        drv(1, 5, 32'hAA, 0, 0, 0, 0, 0);
        #1;
        chk("prio_pipe_wa", 32'(bus.rf_wa), 32'd5);
        chk("prio_pipe_wd", bus.rf_wd, 32'hAA);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("prio_lu_wa", 32'(bus.rf_wa), 32'd7);
        chk("prio_lu_wd", bus.rf_wd, 32'h55);
        cyc();
        chk("prio_busy7", 32'(bus.busy[7]), 32'd0);

        // Fill the queue behind a busy WB stage, then drain
        for (int r = 1; r <= 4; r++) step(1, 2, 32'h2, 0, 0, 0, 1, r);
        for (int r = 1; r <= 4; r++)
            step(1, 2, 32'h2, 1, r, 32'h100 + r, 0, 0);
        drv(1, 2, 32'h2, 1, 5, 32'h105, 0, 0);
        #1;
        chk("full_qcount", 32'(bus.q_count), 32'd4);
        chk("full_ready", 32'(bus.lu_ready), 32'd0);
        chk("full_busy", bus.busy, 32'h1E);
        cyc();
        for (int r = 1; r <= 4; r++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("drain_wa", 32'(bus.rf_wa), 32'(r));
            cyc();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("drain_idle_we", 32'(bus.rf_we), 32'd0);
        chk("drain_busy", bus.busy, 32'd0);
        cyc();

        // Register zero handling
        step(0, 0, 0, 0, 0, 0, 1, 6);
        step(0, 0, 0, 1, 6, 32'h1, 0, 0);
        drv(1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
        #1;
        chk("zero_pipe_pop", 32'(bus.rf_wa), 32'd6);
        cyc();
        step(0, 0, 0, 1, 0, 32'h77, 0, 0);
        chk("zero_lu_qcount", 32'(bus.q_count), 32'd0);
        chk("zero_lu_err", 32'(bus.err), 32'd0);

        // Scoreboard collisions
        step(0, 0, 0, 0, 0, 0, 1, 9);
        step(0, 0, 0, 1, 9, 32'h99, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 9);
        chk("coll_busy9", 32'(bus.busy[9]), 32'd1);
        chk("coll_err", 32'(bus.err), 32'd0);
        step(0, 0, 0, 1, 9, 32'h98, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 0, 1, 3);
        chk("dup_err", 32'(bus.err), 32'd1);
        repeat (3) idle();
        chk("dup_err_sticky", 32'(bus.err), 32'd1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("dup_err_cleared", 32'(bus.err), 32'd0);

        // Reset with work in flight
        for (int r = 1; r <= 3; r++) step(1, 4, 32'h4, 0, 0, 0, 1, r);
        for (int r = 1; r <= 3; r++)
            step(1, 4, 32'h4, 1, r, 32'h300 + r, 0, 0);
        drv(1, 4, 32'h4, 0, 0, 0, 0, 0);
        #1;
        chk("mid_qcount", 32'(bus.q_count), 32'd3);
        chk("mid_busy", bus.busy, 32'h0E);
        cyc();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("mid_rst_qcount", 32'(bus.q_count), 32'd0);
        chk("mid_rst_busy", bus.busy, 32'd0);
        repeat (6) idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            busy_list.delete();
            for (int r = 1; r < NREG; r++)
                if (mbusy[r]) busy_list.push_back(r);
            lwa = 0;
            if (busy_list.size() > 0 && $urandom_range(0, 7) != 0)
                lwa = busy_list[$urandom_range(0, busy_list.size() - 1)];
            rst = (n % 128 == 127);
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
                 $urandom,
                 $urandom_range(0, 1) == 1, lwa, $urandom,
                 $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 31)));
        end
        rst = 1'b0;
        repeat (8) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
